mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_mem_pkg.sv | 30 +++
 rtl/mem_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package riscv_mem_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Data wins a tie unless it owned the previous grant.
    function automatic owner_e pick_winner(input logic if_req, input logic d_req,
                                           input owner_e last);
        if (if_req && d_req) begin
            return (last == OWN_DATA) ? OWN_IF : OWN_DATA;
        end else if (d_req) begin
            return OWN_DATA;
        end
        return OWN_IF;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts BUSY cycles; expired is high during the TIMEOUT-th consecutive enabled cycle.
module mem_watchdog
    import riscv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port memory bus, with a watchdog on BUSY.
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's command
// BUSY  | mem_req held, waiting for mem_ack or watchdog expiry
// DONE  | owner's valid (and err on timeout) asserted for exactly one cycle
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);
    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_q, last_d;
    owner_e                winner;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [DATA_W/8-1:0]   mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic                  wd_expired;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_BUSY),
        .enable  (state_q == ST_BUSY),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        winner      = pick_winner(if_req, d_req, last_q);
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d   = winner;
                    last_d    = winner;
                    mem_req_d = 1'b1;
                    state_d   = ST_BUSY;
                    if (winner == OWN_DATA) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wmask_d = d_wmask;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (wd_expired) begin
                    // An aborted transaction always leaves zero in the owner's read register.
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign if_valid  = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign d_valid   = (state_q == ST_DONE) && (owner_q == OWN_DATA);
    assign if_stall  = if_req && !if_valid;
    assign d_stall   = d_req && !d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid, if_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [MW-1:0] d_wmask = '0;
    logic [DW-1:0] d_rdata;
    logic          d_valid, d_stall, err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, its age, and a completion cycle.
    bit            t_open, t_finish, t_data, t_we, t_timed_out, last_data;
    int            t_age;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [MW-1:0] t_wmask;
    logic [DW-1:0] m_if_rdata, m_d_rdata;

    logic          s_rst, s_if_req, s_d_req, s_d_we, s_ack;
    logic [AW-1:0] s_if_addr, s_d_addr;
    logic [DW-1:0] s_d_wdata, s_rdata;
    logic [MW-1:0] s_d_wmask;

    task automatic model_reset();
        t_open = 0; t_finish = 0; t_data = 0; t_we = 0; t_timed_out = 0;
        last_data = 0; t_age = 0;
        m_if_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] v;
        if (!s_rst) begin
            model_reset();
            return;
        end
        if (t_finish) begin
            t_finish = 0;
        end else if (t_open) begin
            t_age++;
            if (s_ack || t_age == TO) begin
                t_open      = 0;
                t_finish    = 1;
                t_timed_out = !s_ack;
                v = s_ack ? s_rdata : '0;
                if (!t_data) m_if_rdata = v;
                else if (!t_we || !s_ack) m_d_rdata = v;
            end
        end else if (s_if_req || s_d_req) begin
            t_data    = s_d_req && (!s_if_req || !last_data);
            last_data = t_data;
            t_we      = t_data ? s_d_we : 1'b0;
            t_addr    = t_data ? s_d_addr : s_if_addr;
            t_wdata   = s_d_wdata;
            t_wmask   = s_d_wmask;
            t_open    = 1;
            t_age     = 0;
        end
    endtask

    task automatic compare();
        check("mem_req", mem_req, t_open);
        check("if_valid", if_valid, t_finish && !t_data);
        check("d_valid", d_valid, t_finish && t_data);
        check("err", err, t_finish && t_timed_out);
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("if_stall", if_stall, if_req && !(t_finish && !t_data));
        check("d_stall", d_stall, d_req && !(t_finish && t_data));
        if (t_open) begin
            check("mem_we", mem_we, t_we);
            check("mem_addr", mem_addr, t_addr);
            if (t_data) begin
                check("mem_wdata", mem_wdata, t_wdata);
                check("mem_wmask", mem_wmask, t_wmask);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        s_rst = rst; s_if_req = if_req; s_if_addr = if_addr;
        s_d_req = d_req; s_d_we = d_we; s_d_addr = d_addr;
        s_d_wdata = d_wdata; s_d_wmask = d_wmask;
        s_ack = mem_ack; s_rdata = mem_rdata;
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        rst = 0;
        model_reset();
        #1;
        compare();
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst err", err, 0);
        check("rst if_rdata", if_rdata, 0);
        check("rst d_rdata", d_rdata, 0);

        // Fetch only, ack in the third BUSY cycle.
        if_req = 1; if_addr = 32'h100;
        #1; check("fetch stall c0", if_stall, 1);
        tick(); check("fetch mem_req c1", mem_req, 1); check("fetch mem_addr", mem_addr, 32'h100);
        tick(); check("fetch stall c2", if_stall, 1);
        tick(); check("fetch stall c3", if_stall, 1);
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick(); check("fetch if_valid c4", if_valid, 1);
        check("fetch if_rdata", if_rdata, 32'h0050_0093);
        check("fetch stall c4", if_stall, 0);
        mem_ack = 0; if_req = 0;
        tick(); check("fetch if_valid c5", if_valid, 0);

        // Conflict: data, then fetch, then data again.
        do_reset();
        if_req = 1; if_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
        tick(); check("conf grant1 addr", mem_addr, 32'h2000);
        mem_ack = 1; mem_rdata = 32'h1111_0001;
        tick(); check("conf d_valid1", d_valid, 1); check("conf d_rdata1", d_rdata, 32'h1111_0001);
        mem_ack = 0; d_addr = 32'h2004;
        tick(); check("conf idle mem_req", mem_req, 0);
        tick(); check("conf grant2 addr", mem_addr, 32'h1000);
        mem_ack = 1; mem_rdata = 32'h2222_0002;
        tick(); check("conf if_valid", if_valid, 1); check("conf if_rdata", if_rdata, 32'h2222_0002);
        mem_ack = 0;
        tick();
        tick(); check("conf grant3 addr", mem_addr, 32'h2004);
        mem_ack = 1; mem_rdata = 32'h3333_0003;
        tick(); check("conf d_valid3", d_valid, 1); check("conf d_rdata3", d_rdata, 32'h3333_0003);
        mem_ack = 0; if_req = 0; d_req = 0;
        tick();

        // Store: command stable across BUSY; d_rdata keeps the previous load value.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
        tick();
        for (int c = 1; c <= 3; c++) begin
            check("store mem_req", mem_req, 1);
            check("store mem_we", mem_we, 1);
            check("store mem_addr", mem_addr, 32'h200);
            check("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("store mem_wmask", mem_wmask, 4'hF);
            d_addr = 32'hFFFF_FFF0;
            if (c == 3) begin mem_ack = 1; mem_rdata = 32'h5555_AAAA; end
            tick();
        end
        check("store d_valid", d_valid, 1);
        check("store d_rdata", d_rdata, 32'h3333_0003);
        mem_ack = 0; d_req = 0; d_we = 0;
        tick();

        // Timeout, then ack exactly on the last allowed BUSY cycle.
        d_req = 1; d_addr = 32'h300;
        tick();
        for (int c = 1; c <= TO; c++) begin
            check("to busy mem_req", mem_req, 1);
            check("to busy err", err, 0);
            tick();
        end
        check("to d_valid", d_valid, 1); check("to err", err, 1); check("to d_rdata", d_rdata, 0);
        d_req = 0;
        tick(); check("to err clears", err, 0);
        d_req = 1; d_addr = 32'h304;
        tick();
        for (int c = 1; c <= TO; c++) begin
            if (c == TO) begin mem_ack = 1; mem_rdata = 32'h7777_0007; end
            tick();
        end
        check("late ack d_valid", d_valid, 1); check("late ack err", err, 0);
        check("late ack d_rdata", d_rdata, 32'h7777_0007);
        mem_ack = 0; d_req = 0;
        tick();

        // Reset during BUSY abandons the transaction.
        if_req = 1; if_addr = 32'h400;
        tick();
        tick();
        rst = 0; if_req = 0;
        model_reset();
        #1; check("rst busy mem_req", mem_req, 0);
        #1; rst = 1;
        tick();
        mem_ack = 1; mem_rdata = 32'h9999_9999;
        tick(); check("rst late if_valid", if_valid, 0); check("rst late d_valid", d_valid, 0);
        check("rst late if_rdata", if_rdata, 0);
        mem_ack = 0; if_req = 1; if_addr = 32'h404;
        tick(); check("post rst addr", mem_addr, 32'h404);
        mem_ack = 1; mem_rdata = 32'hABCD_1234;
        tick(); check("post rst if_valid", if_valid, 1); check("post rst if_rdata", if_rdata, 32'hABCD_1234);
        mem_ack = 0; if_req = 0;
        tick();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if (if_req && t_finish && !t_data) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end else if (if_req && $urandom_range(0, 7) == 0) begin
                if_addr = $urandom;
            end
            if (d_req && t_finish && t_data) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
            end else if (d_req && $urandom_range(0, 7) == 0) begin
                d_addr = $urandom; d_wdata = $urandom;
            end
            mem_rdata = $urandom;
            mem_ack = t_open ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 0;
                model_reset();
                #1;
                compare();
                tick();
                rst = 1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
